// File: rtl/alu_pkg.sv
// Purpose: shared types for the alu_pipe slice: opcode enum, {N,V,Z} flag struct, flag bit indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD    = 3'b000,
    OP_SUB    = 3'b001,
    OP_XOR    = 3'b010,
    OP_RED    = 3'b011,
    OP_SLL    = 3'b100,
    OP_SRA    = 3'b101,
    OP_ROR    = 3'b110,
    OP_PADDSB = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic n;
    logic v;
    logic z;
  } flags_t;

  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  // Only ADD/SUB own the N and V flags; every other op leaves them alone.
  function automatic logic is_arith(alu_op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Purpose: valid/ready operation bus into alu_pipe and result bus out of it.
// Latency: n/a (wiring only).
// Backpressure: producer holds in_* while in_valid && !in_ready; consumer drives out_ready.
// Ports: in_valid/in_ready/in_op/in_a/in_b (request), out_valid/out_ready/out_data/flags (result).
interface alu_pipe_if #(
  parameter int W = 16
);
  import alu_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  flags_t       flags;

  // Request source / result sink side.
  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, flags
  );

  // ALU side.
  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, flags
  );

endinterface

// File: rtl/alu_pipe_core.sv
// Purpose: combinational ALU datapath (ADD/SUB sat-or-wrap, XOR, byte sum, shifts, rotate, 4-bit SIMD sat add).
// Latency: 0 cycles, pure combinational.
// Backpressure: none; evaluated every cycle on whatever S1 holds.
// Ports: op, a, b in; result, n (result MSB), v (signed overflow of ADD/SUB, else 0), z (result == 0) out.
module alu_pipe_core
  import alu_pkg::*;
#(
  parameter int W   = 16,
  parameter bit SAT = 1'b1
) (
  input  alu_op_e      op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         n,
  output logic         v,
  output logic         z
);

  localparam int AW = $clog2(W);
  localparam int NB = W / 8;  // bytes per operand
  localparam int NL = W / 4;  // nibble lanes for PADDSB

  logic [AW-1:0] amt;
  logic [W:0]    add_ext;
  logic [W:0]    sub_ext;
  logic          add_ovf;
  logic          sub_ovf;
  logic [W-1:0]  red_sum;
  logic [W-1:0]  paddsb_dat;
  logic [4:0]    lane;

  assign amt = b[AW-1:0];

  // One extra sign bit: overflow whenever the top two bits disagree, and the
  // top bit is the sign of the true result, which picks the clamp direction.
  assign add_ext = {a[W-1], a} + {b[W-1], b};
  assign sub_ext = {a[W-1], a} - {b[W-1], b};
  assign add_ovf = add_ext[W] ^ add_ext[W-1];
  assign sub_ovf = sub_ext[W] ^ sub_ext[W-1];

  function automatic logic [W-1:0] clamp(logic neg);
    return neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  endfunction

  // Sum of all bytes of a and b, each sign-extended; at most 2*NB*128 in
  // magnitude, which always fits in W bits since W >= 16.
  always_comb begin
    red_sum = '0;
    for (int i = 0; i < NB; i++) begin
      red_sum = red_sum + {{(W-8){a[8*i+7]}}, a[8*i +: 8]};
      red_sum = red_sum + {{(W-8){b[8*i+7]}}, b[8*i +: 8]};
    end
  end

  // Independent signed nibble lanes, each clamped to [-8, 7].
  always_comb begin
    paddsb_dat = '0;
    lane       = '0;
    for (int j = 0; j < NL; j++) begin
      lane = {a[4*j+3], a[4*j +: 4]} + {b[4*j+3], b[4*j +: 4]};
      if (lane[4] != lane[3]) begin
        paddsb_dat[4*j +: 4] = lane[4] ? 4'h8 : 4'h7;
      end else begin
        paddsb_dat[4*j +: 4] = lane[3:0];
      end
    end
  end

  always_comb begin
    result = '0;
    v      = 1'b0;
    unique case (op)
      OP_ADD: begin
        v      = add_ovf;
        result = (SAT && add_ovf) ? clamp(add_ext[W]) : add_ext[W-1:0];
      end
      OP_SUB: begin
        v      = sub_ovf;
        result = (SAT && sub_ovf) ? clamp(sub_ext[W]) : sub_ext[W-1:0];
      end
      OP_XOR:    result = a ^ b;
      OP_RED:    result = red_sum;
      OP_SLL:    result = a << amt;
      OP_SRA:    result = $signed(a) >>> amt;
      // Left part shifts by W when amt is 0, which yields 0 and passes a.
      OP_ROR:    result = (a >> amt) | (a << (W - int'(amt)));
      OP_PADDSB: result = paddsb_dat;
      default:   result = '0;
    endcase
  end

  assign n = result[W-1];
  assign z = (result == '0);

endmodule

// File: rtl/alu_pipe.sv
// Purpose: two-stage valid/ready ALU pipeline; S1 holds op/operands, S2 holds result and {N,V,Z} flags.
// Latency: out_valid rises exactly 2 cycles after accept when unstalled; one op per cycle throughput.
// Backpressure: S2 stalls while out_valid && !out_ready; S1 then fills and drops in_ready; outputs hold.
// Ports: clk, rst_n (async active-low), bus (alu_pipe_if.slave). W: multiple of 8, >= 16; SAT: 1 saturate, 0 wrap.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int W   = 16,
  parameter bit SAT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_pipe_if.slave    bus
);

  logic         s1_vld;
  alu_op_e      s1_op;
  logic [W-1:0] s1_a;
  logic [W-1:0] s1_b;

  logic         s2_vld;
  logic [W-1:0] s2_dat;
  flags_t       flags_q;
  flags_t       flags_d;

  logic         s2_free;
  logic         s1_move;
  logic         accept;

  logic [W-1:0] core_res;
  logic         core_n;
  logic         core_v;
  logic         core_z;

  // S2 can take a new result if empty or being drained this cycle; S1 can
  // take a new op if empty or handing its op to S2 this cycle.
  assign s2_free      = !s2_vld || bus.out_ready;
  assign s1_move      = s1_vld && s2_free;
  assign bus.in_ready = !s1_vld || s1_move;
  assign accept       = bus.in_valid && bus.in_ready;

  // Stage 1: operands are only captured on accept, so idle X on the inputs
  // never enters the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_op  <= OP_ADD;
      s1_a   <= '0;
      s1_b   <= '0;
    end else begin
      if (bus.in_ready) begin
        s1_vld <= bus.in_valid;
      end
      if (accept) begin
        s1_op <= alu_op_e'(bus.in_op);
        s1_a  <= bus.in_a;
        s1_b  <= bus.in_b;
      end
    end
  end

  alu_pipe_core #(
    .W   (W),
    .SAT (SAT)
  ) u_core (
    .op     (s1_op),
    .a      (s1_a),
    .b      (s1_b),
    .result (core_res),
    .n      (core_n),
    .v      (core_v),
    .z      (core_z)
  );

  // Z follows every result; N and V only move for ADD/SUB.
  always_comb begin
    flags_d         = flags_q;
    flags_d[FLAG_Z] = core_z;
    if (is_arith(s1_op)) begin
      flags_d[FLAG_N] = core_n;
      flags_d[FLAG_V] = core_v;
    end
  end

  // Stage 2: result and flags load together, only when an op moves up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld  <= 1'b0;
      s2_dat  <= '0;
      flags_q <= '0;
    end else begin
      if (s2_free) begin
        s2_vld <= s1_vld;
      end
      if (s1_move) begin
        s2_dat  <= core_res;
        flags_q <= flags_d;
      end
    end
  end

  assign bus.out_valid = s2_vld;
  assign bus.out_data  = s2_dat;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Purpose: directed self-checking bench for alu_pipe at W=16 (SAT=1 main instance, SAT=0 wrap instance).
// Latency: checks exact 2-cycle accept-to-out_valid latency.
// Backpressure: exercises out_ready stalls, in_ready drop, ordering and mid-flight reset.
module tb_alu_pipe;
  import alu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  alu_pipe_if #(.W(16)) bus ();
  alu_pipe_if #(.W(16)) bus0 ();

  alu_pipe #(.W(16), .SAT(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  alu_pipe #(.W(16), .SAT(1'b0)) dut_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one op with out_ready high and reports what came out and after how many cycles.
  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] d, output logic [2:0] f, output int lat);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_a      = a;
    bus.in_b      = b;
    step();
    bus.in_valid = 1'b0;
    lat = -1;
    d   = 'x;
    f   = 'x;
    for (int c = 1; c <= 8; c++) begin
      if (bus.out_valid === 1'b1) begin
        lat = c;
        d   = bus.out_data;
        f   = bus.flags;
        break;
      end
      step();
    end
    if (lat > 0) step();
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_op = 3'b000; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;
    bus0.in_valid = 1'b0; bus0.in_op = 3'b000; bus0.in_a = '0; bus0.in_b = '0; bus0.out_ready = 1'b1;
    rst_n = 1'b0;
    #12;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.flags !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b want 000", bus.flags); end
    vectors++; if (bus.out_data !== 16'h0000) begin miscompares++; $display("FAIL reset_out_data: got %h want 0000", bus.out_data); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    step();
  endtask

  task automatic test_add_sat();
    logic [15:0] d; logic [2:0] f; int lat;
    run_op(OP_ADD, 16'h7FFF, 16'h0001, d, f, lat);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL add_latency: got %0d want 2", lat); end
    vectors++; if (d !== 16'h7FFF) begin miscompares++; $display("FAIL add_sat_data: got %h want 7fff", d); end
    vectors++; if (f !== 3'b010) begin miscompares++; $display("FAIL add_sat_flags: got %b want 010", f); end
    run_op(OP_ADD, 16'h0001, 16'h0002, d, f, lat);
    vectors++; if (d !== 16'h0003) begin miscompares++; $display("FAIL add_plain_data: got %h want 0003", d); end
    vectors++; if (f !== 3'b000) begin miscompares++; $display("FAIL add_plain_flags: got %b want 000", f); end
  endtask

  task automatic test_add_wrap();
    bus0.in_valid = 1'b1; bus0.in_op = OP_ADD; bus0.in_a = 16'h7FFF; bus0.in_b = 16'h0001;
    step();
    bus0.in_valid = 1'b0;
    vectors++; if (bus0.out_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_early_valid: got %b want 0", bus0.out_valid); end
    step();
    vectors++; if (bus0.out_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_valid: got %b want 1", bus0.out_valid); end
    vectors++; if (bus0.out_data !== 16'h8000) begin miscompares++; $display("FAIL wrap_data: got %h want 8000", bus0.out_data); end
    vectors++; if (bus0.flags !== 3'b110) begin miscompares++; $display("FAIL wrap_flags: got %b want 110", bus0.flags); end
    step();
  endtask

  task automatic test_sub_xor();
    logic [15:0] d; logic [2:0] f; int lat;
    run_op(OP_SUB, 16'h8000, 16'h0001, d, f, lat);
    vectors++; if (d !== 16'h8000) begin miscompares++; $display("FAIL sub_sat_data: got %h want 8000", d); end
    vectors++; if (f !== 3'b110) begin miscompares++; $display("FAIL sub_sat_flags: got %b want 110", f); end
    run_op(OP_XOR, 16'h1234, 16'h1234, d, f, lat);
    vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL xor_data: got %h want 0000", d); end
    vectors++; if (f !== 3'b111) begin miscompares++; $display("FAIL xor_flags: got %b want 111", f); end
  endtask

  task automatic test_shifts();
    logic [15:0] d; logic [2:0] f; int lat;
    run_op(OP_ROR, 16'h0001, 16'h0001, d, f, lat);
    vectors++; if (d !== 16'h8000) begin miscompares++; $display("FAIL ror_data: got %h want 8000", d); end
    vectors++; if (f !== 3'b110) begin miscompares++; $display("FAIL ror_flags: got %b want 110", f); end
    run_op(OP_SRA, 16'h8000, 16'h000F, d, f, lat);
    vectors++; if (d !== 16'hFFFF) begin miscompares++; $display("FAIL sra_data: got %h want ffff", d); end
    run_op(OP_SLL, 16'h00F0, 16'h0000, d, f, lat);
    vectors++; if (d !== 16'h00F0) begin miscompares++; $display("FAIL sll0_data: got %h want 00f0", d); end
    run_op(OP_SLL, 16'h00F0, 16'h0004, d, f, lat);
    vectors++; if (d !== 16'h0F00) begin miscompares++; $display("FAIL sll4_data: got %h want 0f00", d); end
    run_op(OP_RED, 16'h0101, 16'h01FF, d, f, lat);
    vectors++; if (d !== 16'h0002) begin miscompares++; $display("FAIL red_data: got %h want 0002", d); end
    run_op(OP_RED, 16'h8080, 16'h8080, d, f, lat);
    vectors++; if (d !== 16'hFE00) begin miscompares++; $display("FAIL red_neg_data: got %h want fe00", d); end
  endtask

  task automatic test_paddsb();
    logic [15:0] d; logic [2:0] f; int lat;
    run_op(OP_PADDSB, 16'h7777, 16'h1111, d, f, lat);
    vectors++; if (d !== 16'h7777) begin miscompares++; $display("FAIL paddsb_pos_data: got %h want 7777", d); end
    run_op(OP_PADDSB, 16'h8888, 16'hFFFF, d, f, lat);
    vectors++; if (d !== 16'h8888) begin miscompares++; $display("FAIL paddsb_neg_data: got %h want 8888", d); end
    run_op(OP_PADDSB, 16'h1234, 16'h1111, d, f, lat);
    vectors++; if (d !== 16'h2345) begin miscompares++; $display("FAIL paddsb_mid_data: got %h want 2345", d); end
    vectors++; if (f !== 3'b110) begin miscompares++; $display("FAIL paddsb_flags: got %b want 110", f); end
  endtask

  task automatic test_idle_x();
    bus.in_valid = 1'b0; bus.in_op = OP_ADD; bus.in_a = 'x; bus.in_b = 'x; bus.out_ready = 1'b1;
    step(); step(); step();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL idle_out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.flags !== 3'b110) begin miscompares++; $display("FAIL idle_flags: got %b want 110", bus.flags); end
    bus.in_a = '0; bus.in_b = '0;
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops [5] = '{OP_ADD, OP_SUB, OP_XOR, OP_SLL, OP_ROR};
    logic [15:0] as  [5] = '{16'h0001, 16'h0005, 16'h00FF, 16'h0001, 16'h00F0};
    logic [15:0] bs  [5] = '{16'h0002, 16'h0007, 16'h0F0F, 16'h0004, 16'h0004};
    logic [15:0] exp [5] = '{16'h0003, 16'hFFFE, 16'h0FF0, 16'h0010, 16'h000F};
    int sent = 0;
    int got  = 0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      bus.out_ready = (cyc >= 4);
      bus.in_valid  = (sent < 5);
      if (sent < 5) begin
        bus.in_op = ops[sent]; bus.in_a = as[sent]; bus.in_b = bs[sent];
      end
      #1;
      if (cyc == 2) begin
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_in_ready_stall: got %b want 0", bus.in_ready); end
        vectors++; if (sent != 2) begin miscompares++; $display("FAIL b2b_accepts_before_stall: got %0d want 2", sent); end
      end
      if (cyc == 3) begin
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_hold_valid: got %b want 1", bus.out_valid); end
        vectors++; if (bus.out_data !== exp[0]) begin miscompares++; $display("FAIL b2b_hold_data: got %h want %h", bus.out_data, exp[0]); end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        vectors++; if (bus.out_data !== exp[got]) begin miscompares++; $display("FAIL b2b_result%0d: got %h want %h", got, bus.out_data, exp[got]); end
        got++;
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) sent++;
      step();
    end
    bus.in_valid = 1'b0;
    #1;
    vectors++; if (got != 5) begin miscompares++; $display("FAIL b2b_count: got %0d want 5", got); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_extra_valid: got %b want 0", bus.out_valid); end
    step();
  endtask

  task automatic test_reset_mid();
    int spurious = 0;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_op = OP_ADD; bus.in_a = 16'h7FFF; bus.in_b = 16'h0001;
    step();
    bus.in_op = OP_SUB; bus.in_a = 16'h0000; bus.in_b = 16'h0001;
    step();
    bus.in_valid = 1'b0;
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_pre_valid: got %b want 1", bus.out_valid); end
    vectors++; if (bus.flags !== 3'b010) begin miscompares++; $display("FAIL mid_pre_flags: got %b want 010", bus.flags); end
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.flags !== 3'b000) begin miscompares++; $display("FAIL mid_rst_flags: got %b want 000", bus.flags); end
    vectors++; if (bus.out_data !== 16'h0000) begin miscompares++; $display("FAIL mid_rst_data: got %h want 0000", bus.out_data); end
    step(); step();
    rst_n = 1'b1;
    #1;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_release_in_ready: got %b want 1", bus.in_ready); end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.out_valid !== 1'b0) spurious++;
    end
    vectors++; if (spurious != 0) begin miscompares++; $display("FAIL mid_discard: got %0d outputs want 0", spurious); end
  endtask

  initial begin
    test_reset();
    test_add_sat();
    test_add_wrap();
    test_sub_xor();
    test_shifts();
    test_paddsb();
    test_idle_x();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter W, default 16, datapath width; SHALL be a multiple of 8 and at least 16.
REQ-002 Parameter SAT, default 1; 1 = saturating ADD/SUB, 0 = wrapping ADD/SUB.
REQ-003 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operation offered.
REQ-006 in_ready  output  1  operation accepted when in_valid && in_ready.
REQ-007 in_op  input  3  opcode: 000 ADD, 001 SUB, 010 XOR, 011 RED, 100 SLL, 101 SRA, 110 ROR, 111 PADDSB.
REQ-008 in_a, in_b  input  W  operands; shift/rotate amount is in_b[$clog2(W)-1:0].
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  result consumed when out_valid && out_ready.
REQ-011 out_data  output  W  result.
REQ-012 flags  output  3  registered {N,V,Z}.

Function
REQ-013 Pipeline SHALL have two registered stages: S1 captures op/operands, S2 captures result; accept-to-out_valid latency SHALL be exactly 2 cycles with no stall.
REQ-014 in_ready SHALL be high when S1 is empty or S1 moves to S2 in the same cycle; S1 moves when S2 is empty or S2 is consumed in the same cycle.
REQ-015 Throughput SHALL be one op per cycle while out_ready is high; no op SHALL be dropped, duplicated or reordered under any out_ready pattern.
REQ-016 While out_valid is high and out_ready low, out_data and flags SHALL hold.
REQ-017 ADD/SUB: signed W-bit; on overflow, SAT=1 clamps to max positive/min negative, SAT=0 wraps.
REQ-018 XOR: a ^ b.
REQ-019 RED: signed sum of all 2*W/8 bytes of a and b, sign-extended to W.
REQ-020 SLL/SRA: logical left / arithmetic right shift of a by amount; amount 0 passes a.
REQ-021 ROR: rotate a right by amount; amount 0 passes a.
REQ-022 PADDSB: W/4 independent signed 4-bit lanes, each saturating to [-8,7].
REQ-023 Flags SHALL update on the same edge the result enters S2; Z = (result == 0) for every op.
REQ-024 N and V SHALL update only for ADD/SUB: N = result MSB, V = signed overflow before clamping (reported in both SAT modes); other ops SHALL hold N and V.
REQ-025 Inputs with in_valid low SHALL have no effect; X on in_a/in_b while in_valid is low SHALL NOT reach flags.

Reset
REQ-026 On rst_n low, S1/S2 valid, out_valid and flags SHALL clear to 0 immediately; out_data SHALL be 0.
REQ-027 Reset mid-operation SHALL discard all in-flight ops; in_ready SHALL be high in the first cycle after reset release.

Structure
REQ-028 Package alu_pkg SHALL hold the opcode enum, the {N,V,Z} flag struct and the flag bit-index constants.
REQ-029 Combinational compute SHALL be one sub-module, alu_pipe_core (op, a, b -> result, n, v, z), instanced between S1 and S2.

Verification (W=16)
REQ-030 SAT=1, ADD 0x7FFF+0x0001 -> out_data 0x7FFF, flags N0 V1 Z0, out_valid exactly 2 cycles after accept; SAT=0 -> 0x8000, N1 V1.
REQ-031 SUB 0x8000-0x0001 (SAT=1) -> 0x8000, N1 V1 Z0; then XOR 0x1234^0x1234 -> 0x0000, Z1, N1 V1 held.
REQ-032 ROR 0x0001 by 1 -> 0x8000; SRA 0x8000 by 15 -> 0xFFFF; SLL 0x00F0 by 0 -> 0x00F0; RED a=0x0101 b=0x01FF -> 0x0002.
REQ-033 PADDSB 0x7777+0x1111 -> 0x7777; 0x8888+0xFFFF -> 0x8888.
REQ-034 Five back-to-back ops with out_ready low for 4 cycles -> in_ready low after two accepts, all five results delivered in order, no loss.
REQ-035 rst_n pulsed low with two ops in flight -> out_valid and flags 0 immediately, neither op emitted, in_ready 1 the first cycle after release.
